slc3_ctrl_seq: RTL and testbench

//  Next-generation SLC-3 instruction sequencer: fetch/decode/execute FSM driving datapath loads, gates and muxes.

---
 rtl/slc3_ctrl_seq_pkg.sv | 44 ++++
 rtl/slc3_ctrl_seq_if.sv | 29 ++
 rtl/slc3_ctrl_seq_wait_timer.sv | 32 +++
 rtl/slc3_ctrl_seq.sv | 137 +++++++++++++
 tb/tb_slc3_ctrl_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_ctrl_seq_pkg.sv
// Shared SLC-3 sequencer types: state encoding, mux select codes, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slc3_ctrl_seq_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_F_MAR, S_F_MEM, S_F_IR, S_P_IR1, S_P_IR2, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR_PC,
    S_LDR_A, S_LDR_M, S_LDR_W, S_STR_A, S_STR_D, S_STR_M, S_PSE1, S_PSE2
  } state_t;

  // Wait counter sized for the largest legal MEM_WAIT (15).
  localparam int WCNT_W = $clog2(16);

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  // States that hold the SRAM strobes and are timed by the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_F_MEM) || (s == S_LDR_M) || (s == S_STR_M);
  endfunction

endpackage

// File: rtl/slc3_ctrl_seq_if.sv
// Control bundle between the SLC-3 sequencer and the IR/BEN datapath + SRAM.
// Latency: n/a (wiring only).
// Backpressure: n/a; Continue is a level handshake sampled by the sequencer.
interface slc3_ctrl_seq_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
           DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
           DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/slc3_ctrl_seq_wait_timer.sv
// SRAM access timer: counts cycles spent in a memory state, flags the last one.
// Latency: done asserts in the MEM_WAIT-th consecutive active cycle.
// Backpressure: none; clears whenever active drops, saturates at MEM_WAIT-1.
module slc3_ctrl_seq_wait_timer
  import slc3_ctrl_seq_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic done
);

  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(MEM_WAIT - 1);

  logic [WCNT_W-1:0] wcnt;

  // Count while in a memory state; any non-memory cycle re-arms to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (!active) begin
      wcnt <= '0;
    end else if (wcnt != LAST) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign done = active && (wcnt == LAST);

endmodule

// File: rtl/slc3_ctrl_seq.sv
// SLC-3 fetch/decode/execute sequencer driving datapath loads, gates, muxes, SRAM strobes.
// Latency: outputs are combinational from state; memory states last MEM_WAIT cycles.
// Backpressure: stalls in pause states until Continue rises then falls.
module slc3_ctrl_seq
  import slc3_ctrl_seq_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_IR = 1'b1
) (
  input logic             Clk,
  input logic             Reset,
  slc3_ctrl_seq_if.master ctl
);

  state_t state, next_state;
  logic   mem_active, wait_done;

  assign mem_active = is_mem_state(state);

  slc3_ctrl_seq_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (Clk),
    .rst   (Reset),
    .active(mem_active),
    .done  (wait_done)
  );

  // State register; reset drops straight to HALTED so strobes release at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_HALTED;
    else       state <= next_state;
  end

  // Next-state and control decode.
  always_comb begin
    next_state     = state;
    ctl.LD_MAR     = 1'b0;  ctl.LD_MDR   = 1'b0;  ctl.LD_IR   = 1'b0;  ctl.LD_BEN  = 1'b0;
    ctl.LD_CC      = 1'b0;  ctl.LD_REG   = 1'b0;  ctl.LD_PC   = 1'b0;  ctl.LD_LED  = 1'b0;
    ctl.GatePC     = 1'b0;  ctl.GateMDR  = 1'b0;  ctl.GateALU = 1'b0;
    ctl.GateMARMUX = 1'b0;
    ctl.PCMUX      = PCMUX_INC;  ctl.ADDR2MUX = ADDR2_ZERO;  ctl.ALUK = ALUK_ADD;
    ctl.DRMUX      = 1'b0;  ctl.SR1MUX   = 1'b0;  ctl.SR2MUX  = 1'b0;  ctl.ADDR1MUX = 1'b0;
    ctl.MIO_EN     = 1'b0;
    ctl.Mem_CE     = 1'b0;  ctl.Mem_UB   = 1'b0;  ctl.Mem_LB  = 1'b0;
    ctl.Mem_OE     = 1'b1;  ctl.Mem_WE   = 1'b1;

    case (state)
      S_HALTED: if (ctl.Run) next_state = S_F_MAR;
      S_F_MAR: begin
        ctl.GatePC = 1'b1;  ctl.LD_MAR = 1'b1;  ctl.LD_PC = 1'b1;  ctl.PCMUX = PCMUX_INC;
        next_state = S_F_MEM;
      end
      S_F_MEM, S_LDR_M: begin
        ctl.Mem_OE = 1'b0;  ctl.MIO_EN = 1'b1;
        if (wait_done) begin
          ctl.LD_MDR = 1'b1;
          next_state = (state == S_F_MEM) ? S_F_IR : S_LDR_W;
        end
      end
      S_F_IR: begin
        ctl.GateMDR = 1'b1;  ctl.LD_IR = 1'b1;
        next_state = PAUSE_IR ? S_P_IR1 : S_DECODE;
      end
      S_P_IR1: if (ctl.Continue)  next_state = S_P_IR2;
      S_P_IR2: if (!ctl.Continue) next_state = S_DECODE;
      S_DECODE: begin
        ctl.LD_BEN = 1'b1;
        case (ctl.Opcode)
          OP_ADD:  next_state = S_ADD;
          OP_AND:  next_state = S_AND;
          OP_NOT:  next_state = S_NOT;
          OP_BR:   next_state = S_BR;
          OP_JMP:  next_state = S_JMP;
          OP_JSR:  next_state = S_JSR;
          OP_LDR:  next_state = S_LDR_A;
          OP_STR:  next_state = S_STR_A;
          OP_PSE:  next_state = S_PSE1;
          default: next_state = S_F_MAR;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        ctl.SR1MUX = 1'b1;  ctl.GateALU = 1'b1;  ctl.LD_REG = 1'b1;  ctl.LD_CC = 1'b1;
        ctl.ALUK   = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
        ctl.SR2MUX = (state != S_NOT) && ctl.IR_5;
        next_state = S_F_MAR;
      end
      S_BR: next_state = ctl.BEN ? S_BR_T : S_F_MAR;
      S_BR_T: begin
        ctl.ADDR1MUX = 1'b0;  ctl.ADDR2MUX = ADDR2_OFF9;  ctl.PCMUX = PCMUX_ADDER;  ctl.LD_PC = 1'b1;
        next_state   = S_F_MAR;
      end
      S_JMP: begin
        ctl.SR1MUX = 1'b1;  ctl.ADDR1MUX = 1'b1;  ctl.ADDR2MUX = ADDR2_ZERO;
        ctl.PCMUX  = PCMUX_ADDER;  ctl.LD_PC = 1'b1;
        next_state = S_F_MAR;
      end
      // R7 is written here before JSR_PC reads SR1, so JSRR R7 jumps to the new R7.
      S_JSR: begin
        ctl.GatePC = 1'b1;  ctl.DRMUX = 1'b1;  ctl.LD_REG = 1'b1;
        next_state = S_JSR_PC;
      end
      S_JSR_PC: begin
        ctl.PCMUX = PCMUX_ADDER;  ctl.LD_PC = 1'b1;
        if (ctl.IR_11) begin
          ctl.ADDR1MUX = 1'b0;  ctl.ADDR2MUX = ADDR2_OFF11;
        end else begin
          ctl.ADDR1MUX = 1'b1;  ctl.SR1MUX = 1'b1;  ctl.ADDR2MUX = ADDR2_ZERO;
        end
        next_state = S_F_MAR;
      end
      S_LDR_A, S_STR_A: begin
        ctl.SR1MUX = 1'b1;  ctl.ADDR1MUX = 1'b1;  ctl.ADDR2MUX = ADDR2_OFF6;
        ctl.GateMARMUX = 1'b1;  ctl.LD_MAR = 1'b1;
        next_state = (state == S_LDR_A) ? S_LDR_M : S_STR_D;
      end
      S_LDR_W: begin
        ctl.GateMDR = 1'b1;  ctl.DRMUX = 1'b0;  ctl.LD_REG = 1'b1;  ctl.LD_CC = 1'b1;
        next_state  = S_F_MAR;
      end
      S_STR_D: begin
        ctl.SR1MUX = 1'b0;  ctl.ALUK = ALUK_PASSA;  ctl.GateALU = 1'b1;
        ctl.MIO_EN = 1'b0;  ctl.LD_MDR = 1'b1;
        next_state = S_STR_M;
      end
      S_STR_M: begin
        ctl.Mem_WE = 1'b0;
        if (wait_done) next_state = S_F_MAR;
      end
      S_PSE1: begin
        ctl.LD_LED = 1'b1;
        if (ctl.Continue) next_state = S_PSE2;
      end
      S_PSE2: if (!ctl.Continue) next_state = S_F_MAR;
      default: next_state = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_ctrl_seq.sv
// Scoreboard bench: four parameter configurations run side by side on random
// instruction streams; expected control words come from a per-instruction
// micro-op script and are compared every cycle by an independent monitor.
module tb_slc3_ctrl_seq;

  typedef struct packed {
    logic rst, run, cont;
    logic [3:0] op;
    logic ir5, ir11, ben;
  } in_t;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mio_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
  } ctrl_t;

  function automatic int cfg_w(input int g);
    return (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 1 : 15;
  endfunction
  function automatic bit cfg_p(input int g);
    return (g == 0 || g == 2);
  endfunction

  logic  clk = 1'b0;
  in_t   drv [4];
  ctrl_t act [4];
  ctrl_t exp_q [4][$];
  ctrl_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : cfg
    slc3_ctrl_seq_if ifc ();
    assign ifc.Run      = drv[g].run;
    assign ifc.Continue = drv[g].cont;
    assign ifc.Opcode   = drv[g].op;
    assign ifc.IR_5     = drv[g].ir5;
    assign ifc.IR_11    = drv[g].ir11;
    assign ifc.BEN      = drv[g].ben;
    assign act[g] = {ifc.LD_MAR, ifc.LD_MDR, ifc.LD_IR, ifc.LD_BEN, ifc.LD_CC, ifc.LD_REG,
                     ifc.LD_PC, ifc.LD_LED, ifc.GatePC, ifc.GateMDR, ifc.GateALU, ifc.GateMARMUX,
                     ifc.PCMUX, ifc.DRMUX, ifc.SR1MUX, ifc.SR2MUX, ifc.ADDR1MUX, ifc.ADDR2MUX,
                     ifc.ALUK, ifc.MIO_EN, ifc.Mem_CE, ifc.Mem_UB, ifc.Mem_LB, ifc.Mem_OE, ifc.Mem_WE};
    slc3_ctrl_seq #(.MEM_WAIT(cfg_w(g)), .PAUSE_IR(cfg_p(g))) dut (
      .Clk  (clk),
      .Reset(drv[g].rst),
      .ctl  (ifc)
    );
  end

  // Micro-op words
  function automatic ctrl_t idle();
    ctrl_t c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t mem_read(input bit last);
    ctrl_t c = idle();
    c.mem_oe = 1'b0;
    c.mio_en = 1'b1;
    c.ld_mdr = last;
    return c;
  endfunction

  function automatic in_t mk(input logic [3:0] op, input logic i5, input logic i11, input logic b);
    in_t d;
    d.rst  = 1'b0;
    d.run  = 1'($urandom);
    d.cont = 1'($urandom);
    d.op   = op;
    d.ir5  = i5;
    d.ir11 = i11;
    d.ben  = b;
    return d;
  endfunction

  // One cycle: drive inputs, queue the word expected for this cycle, advance.
  task automatic step(input int g, input in_t d, input ctrl_t e);
    drv[g] = d;
    exp_q[g].push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Continue level handshake: rise (after random low time) then fall (after random hold).
  task automatic handshake(input int g, input in_t d, input ctrl_t w1, input ctrl_t w2);
    int n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin d.cont = 1'b0; step(g, d, w1); end
    d.cont = 1'b1; step(g, d, w1);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin d.cont = 1'b1; step(g, d, w2); end
    d.cont = 1'b0; step(g, d, w2);
  endtask

  task automatic run_cfg(input int g, input int w, input bit p);
    in_t        d;
    ctrl_t      c;
    logic [3:0] op;
    logic       i5, i11, b;
    logic [3:0] ops [13];
    bit         rst_done = 1'b0;
    bit         aborted;
    int         idx;
    ops = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b0000, 4'b1100, 4'b0100,
            4'b0100, 4'b0110, 4'b0111, 4'b1101, 4'b0010, 4'b1111};
    d = '0;
    d.rst = 1'b1;
    drv[g] = d;
    @(posedge clk);
    #1;
    step(g, d, idle());
    step(g, d, idle());
    d.rst = 1'b0;
    d.run = 1'b0;
    repeat (3) step(g, d, idle());
    d.run = 1'b1;
    step(g, d, idle());
    for (int k = 0; k < 45; k++) begin
      aborted = 1'b0;
      if (k < 13) begin
        idx = k;  i5 = k[0];  i11 = (k == 6);  b = (k == 4);
      end else begin
        idx = $urandom_range(0, 12);
        i5 = 1'($urandom);  i11 = 1'($urandom);  b = 1'($urandom);
      end
      op = ops[idx];
      d = mk(op, i5, i11, b);
      // fetch
      c = idle(); c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00;
      step(g, d, c);
      for (int i = 0; i < w; i++) step(g, mk(op, i5, i11, b), mem_read(i == w - 1));
      c = idle(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
      step(g, d, c);
      if (p) handshake(g, d, idle(), idle());
      c = idle(); c.ld_ben = 1'b1;
      step(g, d, c);
      // execute
      case (op)
        4'b0001, 4'b0101, 4'b1001: begin
          c = idle(); c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
          c.aluk   = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
          c.sr2mux = (op != 4'b1001) && i5;
          step(g, d, c);
        end
        4'b0000: begin
          step(g, d, idle());
          if (b) begin
            c = idle(); c.pcmux = 2'b10; c.addr2mux = 2'b10; c.ld_pc = 1'b1;
            step(g, d, c);
          end
        end
        4'b1100: begin
          c = idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
          step(g, d, c);
        end
        4'b0100: begin
          c = idle(); c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
          step(g, d, c);
          c = idle(); c.pcmux = 2'b10; c.ld_pc = 1'b1;
          if (i11) c.addr2mux = 2'b11;
          else begin c.addr1mux = 1'b1; c.sr1mux = 1'b1; end
          step(g, d, c);
        end
        4'b0110, 4'b0111: begin
          c = idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
          c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
          step(g, d, c);
          if (op == 4'b0110) begin
            for (int i = 0; i < w; i++) begin
              if (!rst_done && i == w - 1) begin
                // Reset lands mid-cycle on the LD_MDR beat: strobes must drop before sampling.
                drv[g] = d;
                exp_q[g].push_back(idle());
                #2;
                drv[g].rst = 1'b1;
                @(posedge clk);
                #1;
                d.rst = 1'b1; step(g, d, idle());
                d.rst = 1'b0; d.run = 1'b0; step(g, d, idle());
                d.run = 1'b1; step(g, d, idle());
                rst_done = 1'b1;
                aborted  = 1'b1;
                break;
              end
              step(g, mk(op, i5, i11, b), mem_read(i == w - 1));
            end
            if (!aborted) begin
              c = idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
              step(g, d, c);
            end
          end else begin
            c = idle(); c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
            step(g, d, c);
            c = idle(); c.mem_we = 1'b0;
            for (int i = 0; i < w; i++) step(g, mk(op, i5, i11, b), c);
          end
        end
        4'b1101: begin
          c = idle(); c.ld_led = 1'b1;
          handshake(g, d, c, idle());
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: every cycle each DUT presents a control word; compare against the queue head.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (exp_q[g].size() != 0) begin
        mon_e = exp_q[g].pop_front();
        checks++;
        if (act[g] !== mon_e) begin
          errors++;
          $display("FAIL ctrl_word cfg%0d cyc%0d: got %h expected %h", g, cyc, act[g], mon_e);
        end
      end
    end
  end

  initial begin
    fork
      run_cfg(0, cfg_w(0), cfg_p(0));
      run_cfg(1, cfg_w(1), cfg_p(1));
      run_cfg(2, cfg_w(2), cfg_p(2));
      run_cfg(3, cfg_w(3), cfg_p(3));
    join
    repeat (2) @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (exp_q[g].size() != 0) begin
        errors++;
        $display("FAIL queue_drain cfg%0d: %0d words left, expected 0", g, exp_q[g].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
